lif_neuron: RTL and testbench



---
 rtl/snn_pkg.sv | 24 ++
 rtl/lif_neuron_if.sv | 25 ++
 rtl/syn_adder_tree.sv | 30 +++
 rtl/lif_neuron.sv | 97 +++++++++
 tb/tb_lif_neuron.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron blocks: FSM state encoding,
// adder-tree result width and a saturating clamp helper.
package snn_pkg;

    typedef enum logic [0:0] {
        INTEG  = 1'b0,
        REFRAC = 1'b1
    } state_t;

    // Width needed to hold the exact signed sum of n lanes of dw bits.
    function automatic int sum_w(input int dw, input int n);
        return dw + $clog2(n);
    endfunction

    localparam int SUM_W_DEF = sum_w(16, 4);

    // Clamp x into [lo, hi]; callers truncate the result to their own width.
    function automatic longint sat_clamp(input longint x, input longint lo, input longint hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// Control, synapse and status bundle of one LIF neuron.
interface lif_neuron_if #(
    parameter int DW    = 16,
    parameter int N_SYN = 4,
    parameter int CNT_W = 16
);
    logic                    en;
    logic [N_SYN*DW-1:0]     syn_in;
    logic signed [DW-1:0]    threshold;
    logic                    cnt_clr;
    logic                    spike_out;
    logic signed [DW-1:0]    v_mem;
    logic                    refrac_busy;
    logic [CNT_W-1:0]        spike_cnt;

    modport master (
        output en, syn_in, threshold, cnt_clr,
        input  spike_out, v_mem, refrac_busy, spike_cnt
    );

    modport slave (
        input  en, syn_in, threshold, cnt_clr,
        output spike_out, v_mem, refrac_busy, spike_cnt
    );
endinterface

// File: rtl/syn_adder_tree.sv
// Combinational signed adder tree over N_SYN packed lanes, full-width result.
module syn_adder_tree
    import snn_pkg::*;
#(
    parameter int DW    = 16,
    parameter int N_SYN = 4,
    parameter int SW    = sum_w(DW, N_SYN)
) (
    input  logic [N_SYN*DW-1:0] lanes,
    output logic signed [SW-1:0] sum
);
    localparam int LVL = $clog2(N_SYN);
    localparam int NP  = 1 << LVL;

    logic signed [SW-1:0] node [NP];

    // Sign-extend the lanes (zero-pad to a power of two), then reduce pairwise.
    always_comb begin
        for (int j = 0; j < NP; j++) begin
            if (j < N_SYN) node[j] = SW'($signed(lanes[j*DW +: DW]));
            else           node[j] = '0;
        end
        for (int w = NP / 2; w >= 1; w = w / 2) begin
            for (int k = 0; k < w; k++) begin
                node[k] = node[2*k] + node[2*k+1];
            end
        end
        sum = node[0];
    end
endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with refractory period and spike counter.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int DW         = 16,
    parameter int N_SYN      = 4,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC_CYC = 3,
    parameter int V_RESET    = 0,
    parameter int V_MIN      = 0,
    parameter int CNT_W      = 16
) (
    input logic         clk,
    input logic         rst,
    lif_neuron_if.slave bus
);
    localparam int SW  = sum_w(DW, N_SYN);
    localparam int AW  = SW + 1;
    localparam int RCW = $clog2(REFRAC_CYC + 2);
    localparam longint V_HI = (longint'(1) <<< (DW - 1)) - 1;
    localparam logic signed [DW-1:0] VRST = DW'(V_RESET);

    state_t               state;
    logic [RCW-1:0]       rcnt;
    logic                 spike_r;
    logic signed [DW-1:0] v_r;
    logic [CNT_W-1:0]     scnt;

    logic signed [SW-1:0] sum;
    logic signed [AW-1:0] v_ext;
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] v_next;
    logic                 fire;

    syn_adder_tree #(.DW(DW), .N_SYN(N_SYN), .SW(SW)) u_tree (
        .lanes (bus.syn_in),
        .sum   (sum)
    );

    // Leak + integrate at a width that cannot overflow, then clamp and test.
    always_comb begin
        v_ext  = AW'(v_r);
        acc    = v_ext - (v_ext >>> LEAK_SHIFT) + AW'(sum);
        v_next = DW'(sat_clamp(longint'(acc), longint'(V_MIN), V_HI));
        fire   = bus.en && (state == INTEG) && (v_next >= bus.threshold);
    end

    // Membrane / refractory FSM; spike_out is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= INTEG;
            rcnt    <= '0;
            spike_r <= 1'b0;
            v_r     <= VRST;
        end else begin
            spike_r <= 1'b0;
            if (bus.en) begin
                case (state)
                    INTEG: begin
                        if (fire) begin
                            spike_r <= 1'b1;
                            v_r     <= VRST;
                            if (REFRAC_CYC > 0) begin
                                rcnt  <= RCW'(REFRAC_CYC);
                                state <= REFRAC;
                            end
                        end else begin
                            v_r <= v_next;
                        end
                    end
                    REFRAC: begin
                        v_r  <= VRST;
                        rcnt <= rcnt - 1'b1;
                        if (rcnt == RCW'(1)) state <= INTEG;
                    end
                    default: state <= INTEG;
                endcase
            end
        end
    end

    // Saturating spike counter; clear wins over hold but not over a new spike.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt <= '0;
        end else if (bus.cnt_clr) begin
            scnt <= fire ? CNT_W'(1) : '0;
        end else if (fire && (scnt != {CNT_W{1'b1}})) begin
            scnt <= scnt + 1'b1;
        end
    end

    assign bus.spike_out   = spike_r;
    assign bus.v_mem       = v_r;
    assign bus.refrac_busy = (state == REFRAC);
    assign bus.spike_cnt   = scnt;
endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron with a reference model feeding a scoreboard.
module tb_lif_neuron;

    typedef struct {
        logic               spk;
        logic               busy;
        logic signed [15:0] v;
        logic [15:0]        sc;
        logic [3:0]         sc4;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lif_neuron_if #(.DW(16), .N_SYN(4), .CNT_W(16)) bus ();
    lif_neuron_if #(.DW(16), .N_SYN(4), .CNT_W(4))  bus4 ();

    assign bus4.en        = bus.en;
    assign bus4.syn_in    = bus.syn_in;
    assign bus4.threshold = bus.threshold;
    assign bus4.cnt_clr   = bus.cnt_clr;

    lif_neuron dut (.clk(clk), .rst(rst), .bus(bus));
    lif_neuron #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    exp_t q[$];
    int total;
    int bad;
    int stepn;
    int thr;
    int m_v, m_st, m_cnt, m_sc, m_sc4;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, stepn, obs, expv);
        end
    endtask

    task automatic reset_model();
        m_v = 0; m_st = 0; m_cnt = 0; m_sc = 0; m_sc4 = 0;
    endtask

    task automatic step(input logic e, input int l0, input int l1, input int l2, input int l3, input logic clr);
        int   lanes [4];
        int   acc;
        logic f;
        exp_t x;
        lanes = '{l0, l1, l2, l3};
        bus.en        = e;
        bus.cnt_clr   = clr;
        bus.threshold = 16'(thr);
        for (int i = 0; i < 4; i++) bus.syn_in[i*16 +: 16] = 16'(lanes[i]);
        f = 1'b0;
        if (e) begin
            if (m_st == 0) begin
                acc = m_v - (m_v >>> 4) + l0 + l1 + l2 + l3;
                if (acc > 32767) acc = 32767;
                if (acc < 0)     acc = 0;
                if (acc >= thr) begin
                    f = 1'b1; m_v = 0; m_st = 1; m_cnt = 3;
                end else begin
                    m_v = acc;
                end
            end else begin
                m_v = 0;
                m_cnt--;
                if (m_cnt == 0) m_st = 0;
            end
        end
        if (clr) begin
            m_sc = int'(f); m_sc4 = int'(f);
        end else if (f) begin
            if (m_sc < 65535) m_sc++;
            if (m_sc4 < 15)   m_sc4++;
        end
        x.spk = f; x.busy = (m_st == 1); x.v = 16'(m_v); x.sc = 16'(m_sc); x.sc4 = 4'(m_sc4);
        q.push_back(x);
        @(posedge clk); #1;
        stepn++;
        x = q.pop_front();
        chk("spike_out",   bus.spike_out,    x.spk);
        chk("refrac_busy", bus.refrac_busy,  x.busy);
        chk("v_mem",       bus.v_mem,        x.v);
        chk("spike_cnt",   bus.spike_cnt,    x.sc);
        chk("spike_cnt4",  bus4.spike_cnt,   x.sc4);
    endtask

    initial begin
        total = 0; bad = 0; stepn = 0; thr = 1000;
        reset_model();
        rst = 1'b0;
        bus.en = 1'b1; bus.cnt_clr = 1'b0; bus.threshold = 16'(thr);
        for (int i = 0; i < 4; i++) bus.syn_in[i*16 +: 16] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_spike", bus.spike_out, 0);
        chk("rst_v",     bus.v_mem, 0);
        chk("rst_busy",  bus.refrac_busy, 0);
        chk("rst_cnt",   bus.spike_cnt, 0);
        chk("rst_cnt4",  bus4.spike_cnt, 0);
        rst = 1'b1;

        // idle after reset
        repeat (4) step(1, 0, 0, 0, 0, 0);
        chk("idle_v", bus.v_mem, 0);

        // integrate and fire
        step(1, 600, 0, 0, 0, 0);
        chk("int_v600", bus.v_mem, 600);
        step(1, 600, 0, 0, 0, 0);
        chk("fire_spike", bus.spike_out, 1);
        chk("fire_v",     bus.v_mem, 0);
        chk("fire_busy",  bus.refrac_busy, 1);
        chk("fire_cnt",   bus.spike_cnt, 1);

        // refractory: busy for exactly 3 cycles, then integrate, then fire
        for (int k = 0; k < 2; k++) begin
            step(1, 600, 0, 0, 0, 0);
            chk("refrac_hold", bus.refrac_busy, 1);
        end
        step(1, 600, 0, 0, 0, 0);
        chk("refrac_end", bus.refrac_busy, 0);
        step(1, 600, 0, 0, 0, 0);
        chk("reint_v", bus.v_mem, 600);
        step(1, 600, 0, 0, 0, 0);
        chk("refire", bus.spike_out, 1);
        chk("refire_cnt", bus.spike_cnt, 2);

        // enable gating in the middle of REFRAC
        step(1, 600, 0, 0, 0, 0);
        repeat (5) begin
            step(0, 600, 0, 0, 0, 0);
            chk("gate_busy", bus.refrac_busy, 1);
        end
        step(1, 600, 0, 0, 0, 0);
        chk("gate_busy2", bus.refrac_busy, 1);
        step(1, 600, 0, 0, 0, 0);
        chk("gate_done", bus.refrac_busy, 0);

        // saturation at the top, clamp at V_MIN
        thr = 32767;
        step(1, 32767, 32767, 32767, 32767, 0);
        chk("sat_fire", bus.spike_out, 1);
        repeat (3) step(1, -32768, -32768, -32768, -32768, 0);
        repeat (3) step(1, -32768, -32768, -32768, -32768, 0);
        chk("clamp_v", bus.v_mem, 0);
        chk("clamp_nospk", bus.spike_out, 0);
        thr = 1000;

        // cnt_clr while disabled, then coincident with a spike
        step(0, 0, 0, 0, 0, 1);
        chk("clr_noen", bus.spike_cnt, 0);
        step(1, 600, 0, 0, 0, 0);
        step(1, 600, 0, 0, 0, 1);
        chk("clr_spike", bus.spike_cnt, 1);

        // async reset during REFRAC, observed before the next clock edge
        step(1, 600, 0, 0, 0, 0);
        chk("pre_rst_busy", bus.refrac_busy, 1);
        rst = 1'b0;
        #1;
        chk("arst_busy",  bus.refrac_busy, 0);
        chk("arst_v",     bus.v_mem, 0);
        chk("arst_spike", bus.spike_out, 0);
        chk("arst_cnt",   bus.spike_cnt, 0);
        rst = 1'b1;
        reset_model();

        // 20 spikes: 16-bit counter reads 20, 4-bit counter saturates at 15
        repeat (80) step(1, 32767, 32767, 32767, 32767, 0);
        chk("cnt20", bus.spike_cnt, 20);
        chk("cnt4_sat", bus4.spike_cnt, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout step=%0d", stepn);
        $fatal(1, "timeout");
    end

endmodule
